// File: rtl/instruction_encoder_if.sv
// Request/response bundle for the instruction encoder: request fields with
// in_valid/in_ready, encoded word with out_valid/out_ready.
interface instruction_encoder_if #(
   parameter int INSTRUCTION_LENGTH = 32,
   parameter int TYPE_WIDTH         = 3,
   parameter int REGISTER_WIDTH     = 5,
   parameter int IMMEDIATE_WIDTH    = 32
);
   // A transfer happens on a rising clk edge where valid && ready are both 1.
   // The producer keeps valid and its payload steady until that edge, and
   // ready never depends combinationally on valid.
   logic                          in_valid;
   logic                          in_ready;
   logic [TYPE_WIDTH-1:0]         in_type;
   logic [6:0]                    in_opcode;
   logic [2:0]                    in_funct3;
   logic [6:0]                    in_funct7;
   logic                          in_is_shift;
   logic [REGISTER_WIDTH-1:0]     in_rd;
   logic [REGISTER_WIDTH-1:0]     in_rs1;
   logic [REGISTER_WIDTH-1:0]     in_rs2;
   logic [IMMEDIATE_WIDTH-1:0]    in_imm;
   logic                          out_valid;
   logic                          out_ready;
   logic [INSTRUCTION_LENGTH-1:0] out_instruction;
   logic                          out_error;

   modport master (
      output in_valid, in_type, in_opcode, in_funct3, in_funct7, in_is_shift,
             in_rd, in_rs1, in_rs2, in_imm, out_ready,
      input  in_ready, out_valid, out_instruction, out_error
   );

   modport slave (
      input  in_valid, in_type, in_opcode, in_funct3, in_funct7, in_is_shift,
             in_rd, in_rs1, in_rs2, in_imm, out_ready,
      output in_ready, out_valid, out_instruction, out_error
   );
endinterface

// File: rtl/instruction_encoder.sv
// Packs RISC-V instruction fields into a 32-bit word, checks the immediate,
// and buffers results in an output register plus one skid register.
module instruction_encoder #(
   parameter int INSTRUCTION_LENGTH = 32,
   parameter int TYPE_WIDTH         = 3,
   parameter int REGISTER_WIDTH     = 5,
   parameter int IMMEDIATE_WIDTH    = 32,
   parameter int COUNT_WIDTH        = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   instruction_encoder_if.slave   bus,
   output logic [COUNT_WIDTH-1:0] encoded_count,
   output logic [COUNT_WIDTH-1:0] error_count
);
   localparam logic [TYPE_WIDTH-1:0] T_R  = TYPE_WIDTH'(0);
   localparam logic [TYPE_WIDTH-1:0] T_I  = TYPE_WIDTH'(1);
   localparam logic [TYPE_WIDTH-1:0] T_S  = TYPE_WIDTH'(2);
   localparam logic [TYPE_WIDTH-1:0] T_SB = TYPE_WIDTH'(3);
   localparam logic [TYPE_WIDTH-1:0] T_U  = TYPE_WIDTH'(4);
   localparam logic [TYPE_WIDTH-1:0] T_UJ = TYPE_WIDTH'(5);

   localparam logic signed [IMMEDIATE_WIDTH-1:0] IMM12_MIN = IMMEDIATE_WIDTH'(-2048);
   localparam logic signed [IMMEDIATE_WIDTH-1:0] IMM12_MAX = IMMEDIATE_WIDTH'(2047);
   localparam logic signed [IMMEDIATE_WIDTH-1:0] SHAMT_MIN = IMMEDIATE_WIDTH'(0);
   localparam logic signed [IMMEDIATE_WIDTH-1:0] SHAMT_MAX = IMMEDIATE_WIDTH'(31);
   localparam logic signed [IMMEDIATE_WIDTH-1:0] SB_MIN    = IMMEDIATE_WIDTH'(-4096);
   localparam logic signed [IMMEDIATE_WIDTH-1:0] SB_MAX    = IMMEDIATE_WIDTH'(4094);
   localparam logic signed [IMMEDIATE_WIDTH-1:0] UJ_MIN    = IMMEDIATE_WIDTH'(-1048576);
   localparam logic signed [IMMEDIATE_WIDTH-1:0] UJ_MAX    = IMMEDIATE_WIDTH'(1048574);

   logic signed [IMMEDIATE_WIDTH-1:0] imm_s;
   logic [IMMEDIATE_WIDTH-1:0]        imm;
   logic [INSTRUCTION_LENGTH-1:0]     enc_word;
   logic                              enc_err;

   logic                          out_valid_q, out_valid_d;
   logic [INSTRUCTION_LENGTH-1:0] out_word_q, out_word_d;
   logic                          out_err_q, out_err_d;
   logic                          skid_valid_q, skid_valid_d;
   logic [INSTRUCTION_LENGTH-1:0] skid_word_q, skid_word_d;
   logic                          skid_err_q, skid_err_d;
   logic [COUNT_WIDTH-1:0]        encoded_count_q, encoded_count_d;
   logic [COUNT_WIDTH-1:0]        error_count_q, error_count_d;

   logic accept;
   logic drain;

   assign imm   = bus.in_imm;
   assign imm_s = $signed(bus.in_imm);

   always_comb begin
      enc_word = '0;
      enc_err  = 1'b0;
      case (bus.in_type)
         T_R: begin
            enc_word = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3,
                        bus.in_rd, bus.in_opcode};
         end
         T_I: begin
            if (bus.in_is_shift) begin
               enc_word = {bus.in_funct7, imm[4:0], bus.in_rs1, bus.in_funct3,
                           bus.in_rd, bus.in_opcode};
               enc_err  = (imm_s < SHAMT_MIN) || (imm_s > SHAMT_MAX);
            end else begin
               enc_word = {imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd,
                           bus.in_opcode};
               enc_err  = (imm_s < IMM12_MIN) || (imm_s > IMM12_MAX);
            end
         end
         T_S: begin
            enc_word = {imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                        imm[4:0], bus.in_opcode};
            enc_err  = (imm_s < IMM12_MIN) || (imm_s > IMM12_MAX);
         end
         T_SB: begin
            enc_word = {imm[12], imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                        imm[4:1], imm[11], bus.in_opcode};
            enc_err  = (imm_s < SB_MIN) || (imm_s > SB_MAX) || imm[0];
         end
         T_U: begin
            enc_word = {imm[31:12], bus.in_rd, bus.in_opcode};
            enc_err  = (imm[11:0] != 12'd0);
         end
         T_UJ: begin
            enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], bus.in_rd,
                        bus.in_opcode};
            enc_err  = (imm_s < UJ_MIN) || (imm_s > UJ_MAX) || imm[0];
         end
         default: begin
            enc_word = '0;
            enc_err  = 1'b1;
         end
      endcase
   end

   // The skid register is only ever filled when the output register is held,
   // so an empty skid is the whole acceptance condition.
   assign bus.in_ready = !skid_valid_q && !reset;
   assign accept       = bus.in_valid && bus.in_ready;
   assign drain        = out_valid_q && bus.out_ready;

   always_comb begin
      out_valid_d     = out_valid_q;
      out_word_d      = out_word_q;
      out_err_d       = out_err_q;
      skid_valid_d    = skid_valid_q;
      skid_word_d     = skid_word_q;
      skid_err_d      = skid_err_q;
      encoded_count_d = encoded_count_q;
      error_count_d   = error_count_q;

      if (drain) begin
         encoded_count_d = encoded_count_q + COUNT_WIDTH'(1);
         if (out_err_q && (error_count_q != '1)) begin
            error_count_d = error_count_q + COUNT_WIDTH'(1);
         end
         if (skid_valid_q) begin
            out_word_d   = skid_word_q;
            out_err_d    = skid_err_q;
            skid_valid_d = 1'b0;
         end else if (accept) begin
            out_word_d = enc_word;
            out_err_d  = enc_err;
         end else begin
            out_valid_d = 1'b0;
         end
      end else if (accept) begin
         if (!out_valid_q) begin
            out_valid_d = 1'b1;
            out_word_d  = enc_word;
            out_err_d   = enc_err;
         end else begin
            skid_valid_d = 1'b1;
            skid_word_d  = enc_word;
            skid_err_d   = enc_err;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid_q     <= 1'b0;
         out_word_q      <= '0;
         out_err_q       <= 1'b0;
         skid_valid_q    <= 1'b0;
         skid_word_q     <= '0;
         skid_err_q      <= 1'b0;
         encoded_count_q <= '0;
         error_count_q   <= '0;
      end else begin
         out_valid_q     <= out_valid_d;
         out_word_q      <= out_word_d;
         out_err_q       <= out_err_d;
         skid_valid_q    <= skid_valid_d;
         skid_word_q     <= skid_word_d;
         skid_err_q      <= skid_err_d;
         encoded_count_q <= encoded_count_d;
         error_count_q   <= error_count_d;
      end
   end

   assign bus.out_valid       = out_valid_q;
   assign bus.out_instruction = out_word_q;
   assign bus.out_error       = out_err_q;
   assign encoded_count       = encoded_count_q;
   assign error_count         = error_count_q;
endmodule

// File: tb/tb_instruction_encoder.sv
// Bench for instruction_encoder: directed vector table, backpressure and
// reset sequences, then random traffic checked against a field-level model.
module tb_instruction_encoder;
   typedef struct {
      string       name;
      logic [2:0]  typ;
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic        sh;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] imm;
      logic [31:0] exp_word;
      logic        exp_err;
   } vec_t;

   logic        clk;
   logic        reset;
   logic [15:0] encoded_count;
   logic [15:0] error_count;

   instruction_encoder_if bus ();

   instruction_encoder dut (
      .clk           (clk),
      .reset         (reset),
      .bus           (bus),
      .encoded_count (encoded_count),
      .error_count   (error_count)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          checks;
   int          errors;
   int          exp_enc;
   int          exp_errc;
   logic [32:0] exp_q[$];
   vec_t        tab[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input string name, input int typ, input int op, input int f3,
                               input int f7, input int sh, input int rd, input int rs1,
                               input int rs2, input int imm, input logic [31:0] w, input int e);
      vec_t v;
      v.name = name; v.typ = 3'(typ); v.op = 7'(op); v.f3 = 3'(f3); v.f7 = 7'(f7);
      v.sh = 1'(sh); v.rd = 5'(rd); v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.imm = 32'(imm);
      v.exp_word = w; v.exp_err = 1'(e);
      return v;
   endfunction

   // reference model: immediate treated as a signed number, fields cut out
   // arithmetically and placed at their bit offsets
   function automatic longint bits(input longint iv, input int hi, input int lo);
      return (iv >>> lo) & ((64'sd1 <<< (hi - lo + 1)) - 1);
   endfunction

   function automatic logic [31:0] place(input longint val, input int lsb);
      return 32'(val << lsb);
   endfunction

   function automatic logic [32:0] model(input vec_t v);
      longint iv;
      logic [31:0] w;
      logic e;
      iv = longint'($signed(v.imm));
      w = 32'd0;
      e = 1'b0;
      case (int'(v.typ))
         0: w = place(v.f7, 25) | place(v.rs2, 20) | place(v.rs1, 15) | place(v.f3, 12)
                | place(v.rd, 7) | place(v.op, 0);
         1: if (v.sh) begin
               w = place(v.f7, 25) | place(bits(iv, 4, 0), 20) | place(v.rs1, 15)
                   | place(v.f3, 12) | place(v.rd, 7) | place(v.op, 0);
               e = (iv < 0) || (iv > 31);
            end else begin
               w = place(bits(iv, 11, 0), 20) | place(v.rs1, 15) | place(v.f3, 12)
                   | place(v.rd, 7) | place(v.op, 0);
               e = (iv < -2048) || (iv > 2047);
            end
         2: begin
            w = place(bits(iv, 11, 5), 25) | place(v.rs2, 20) | place(v.rs1, 15)
                | place(v.f3, 12) | place(bits(iv, 4, 0), 7) | place(v.op, 0);
            e = (iv < -2048) || (iv > 2047);
         end
         3: begin
            w = place(bits(iv, 12, 12), 31) | place(bits(iv, 10, 5), 25) | place(v.rs2, 20)
                | place(v.rs1, 15) | place(v.f3, 12) | place(bits(iv, 4, 1), 8)
                | place(bits(iv, 11, 11), 7) | place(v.op, 0);
            e = (iv < -4096) || (iv > 4094) || (bits(iv, 0, 0) != 0);
         end
         4: begin
            w = place(bits(iv, 31, 12), 12) | place(v.rd, 7) | place(v.op, 0);
            e = bits(iv, 11, 0) != 0;
         end
         5: begin
            w = place(bits(iv, 20, 20), 31) | place(bits(iv, 10, 1), 21)
                | place(bits(iv, 11, 11), 20) | place(bits(iv, 19, 12), 12)
                | place(v.rd, 7) | place(v.op, 0);
            e = (iv < -1048576) || (iv > 1048574) || (bits(iv, 0, 0) != 0);
         end
         default: begin
            w = 32'd0;
            e = 1'b1;
         end
      endcase
      return {e, w};
   endfunction

   // driver tasks
   task automatic drive(input vec_t v);
      bus.in_type = v.typ; bus.in_opcode = v.op; bus.in_funct3 = v.f3; bus.in_funct7 = v.f7;
      bus.in_is_shift = v.sh; bus.in_rd = v.rd; bus.in_rs1 = v.rs1; bus.in_rs2 = v.rs2;
      bus.in_imm = v.imm;
   endtask

   task automatic apply_vec(input vec_t v);
      @(negedge clk);
      drive(v);
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      check({v.name, "_valid"}, 64'(bus.out_valid), 64'd1);
      check({v.name, "_word"}, 64'(bus.out_instruction), 64'(v.exp_word));
      check({v.name, "_err"}, 64'(bus.out_error), 64'(v.exp_err));
      exp_enc++;
      if (v.exp_err) exp_errc++;
      @(negedge clk);
      check({v.name, "_empty"}, 64'(bus.out_valid), 64'd0);
      check({v.name, "_enc_cnt"}, 64'(encoded_count), 64'(exp_enc));
      check({v.name, "_err_cnt"}, 64'(error_count), 64'(exp_errc));
   endtask

   function automatic vec_t rand_req();
      vec_t v;
      int sel;
      v.name = "rnd";
      v.typ = 3'($urandom_range(0, 7)); v.op = 7'($urandom); v.f3 = 3'($urandom);
      v.f7 = 7'($urandom); v.sh = 1'($urandom); v.rd = 5'($urandom);
      v.rs1 = 5'($urandom); v.rs2 = 5'($urandom);
      sel = $urandom_range(0, 3);
      case (sel)
         0: v.imm = $urandom;
         1: v.imm = 32'($urandom_range(0, 8200)) - 32'd4100;
         2: v.imm = 32'($urandom_range(0, 64)) - 32'd16;
         default: v.imm = 32'($urandom_range(1048560, 1048590))
                          * (($urandom_range(0, 1) == 1) ? 32'd1 : 32'hFFFF_FFFF);
      endcase
      if ($urandom_range(0, 3) == 0) v.imm = v.imm & 32'hFFFF_F000;
      v.exp_word = '0; v.exp_err = 1'b0;
      return v;
   endfunction

   initial begin
      vec_t a, b, c, cur;
      logic have_cur;
      logic prev_hold;
      logic [32:0] prev_out;
      logic [32:0] got;
      int base;

      checks = 0; errors = 0; exp_enc = 0; exp_errc = 0;
      bus.in_valid = 1'b0; bus.out_ready = 1'b0;
      bus.in_type = '0; bus.in_opcode = '0; bus.in_funct3 = '0; bus.in_funct7 = '0;
      bus.in_is_shift = 1'b0; bus.in_rd = '0; bus.in_rs1 = '0; bus.in_rs2 = '0; bus.in_imm = '0;
      reset = 1'b1;

      tab.push_back(mk("r_add", 0, 'h33, 0, 0, 0, 3, 1, 2, 0, 32'h002081B3, 0));
      tab.push_back(mk("i_addi_m1", 1, 'h13, 0, 0, 0, 1, 0, 0, -1, 32'hFFF00093, 0));
      tab.push_back(mk("i_addi_2048", 1, 'h13, 0, 0, 0, 1, 0, 0, 2048, 32'h80000093, 1));
      tab.push_back(mk("i_addi_m2048", 1, 'h13, 0, 0, 0, 1, 0, 0, -2048, 32'h80000093, 0));
      tab.push_back(mk("sb_beq_m4", 3, 'h63, 0, 0, 0, 0, 1, 2, -4, 32'hFE208EE3, 0));
      tab.push_back(mk("sb_beq_3", 3, 'h63, 0, 0, 0, 0, 1, 2, 3, 32'h00208163, 1));
      tab.push_back(mk("sb_beq_4094", 3, 'h63, 0, 0, 0, 0, 1, 2, 4094, 32'h7E208FE3, 0));
      tab.push_back(mk("uj_jal_800", 5, 'h6F, 0, 0, 0, 1, 0, 0, 'h800, 32'h001000EF, 0));
      tab.push_back(mk("uj_jal_max", 5, 'h6F, 0, 0, 0, 1, 0, 0, 1048574, 32'h7FFFF0EF, 0));
      tab.push_back(mk("uj_jal_over", 5, 'h6F, 0, 0, 0, 1, 0, 0, 1048576, 32'h800000EF, 1));
      tab.push_back(mk("type6", 6, 'h33, 1, 1, 0, 3, 1, 2, 5, 32'h00000000, 1));
      tab.push_back(mk("u_lui", 4, 'h37, 0, 0, 0, 5, 0, 0, 'h12345000, 32'h123452B7, 0));
      tab.push_back(mk("u_lui_low", 4, 'h37, 0, 0, 0, 5, 0, 0, 'h12345001, 32'h123452B7, 1));
      tab.push_back(mk("i_srai_3", 1, 'h13, 5, 'h20, 1, 2, 2, 0, 3, 32'h40315113, 0));
      tab.push_back(mk("i_srai_32", 1, 'h13, 5, 'h20, 1, 2, 2, 0, 32, 32'h40015113, 1));
      tab.push_back(mk("s_sw_m8", 2, 'h23, 2, 0, 0, 0, 2, 5, -8, 32'hFE512C23, 0));

      // reset values
      repeat (3) @(negedge clk);
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_out_instr", 64'(bus.out_instruction), 64'd0);
      check("rst_out_error", 64'(bus.out_error), 64'd0);
      check("rst_enc_cnt", 64'(encoded_count), 64'd0);
      check("rst_err_cnt", 64'(error_count), 64'd0);
      check("rst_in_ready", 64'(bus.in_ready), 64'd0);
      reset = 1'b0;
      #1 check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

      foreach (tab[i]) apply_vec(tab[i]);

      // backpressure: two accepted, third waits for the first drain
      a = tab[0]; b = tab[1]; c = tab[7];
      base = exp_enc;
      @(negedge clk);
      bus.out_ready = 1'b0; drive(a); bus.in_valid = 1'b1;
      #1 check("bp_ready_1", 64'(bus.in_ready), 64'd1);
      @(negedge clk);
      drive(b);
      #1 check("bp_ready_2", 64'(bus.in_ready), 64'd1);
      @(negedge clk);
      drive(c);
      #1 check("bp_full", 64'(bus.in_ready), 64'd0);
      check("bp_head_a", 64'(bus.out_instruction), 64'(a.exp_word));
      @(negedge clk);
      #1 check("bp_still_full", 64'(bus.in_ready), 64'd0);
      check("bp_hold_a", 64'(bus.out_instruction), 64'(a.exp_word));
      bus.out_ready = 1'b1;
      @(negedge clk);
      #1 check("bp_head_b", 64'(bus.out_instruction), 64'(b.exp_word));
      check("bp_ready_after_drain", 64'(bus.in_ready), 64'd1);
      @(negedge clk);
      bus.in_valid = 1'b0;
      #1 check("bp_head_c", 64'(bus.out_instruction), 64'(c.exp_word));
      check("bp_valid_c", 64'(bus.out_valid), 64'd1);
      @(negedge clk);
      check("bp_empty", 64'(bus.out_valid), 64'd0);
      check("bp_enc_cnt", 64'(encoded_count), 64'(base + 3));

      // reset with both entries occupied
      @(negedge clk);
      bus.out_ready = 1'b0; drive(a); bus.in_valid = 1'b1;
      @(negedge clk);
      drive(b);
      @(negedge clk);
      bus.in_valid = 1'b0;
      #1 check("mid_full", 64'(bus.in_ready), 64'd0);
      #2 reset = 1'b1;
      #1 check("mid_rst_valid", 64'(bus.out_valid), 64'd0);
      check("mid_rst_instr", 64'(bus.out_instruction), 64'd0);
      check("mid_rst_enc_cnt", 64'(encoded_count), 64'd0);
      check("mid_rst_err_cnt", 64'(error_count), 64'd0);
      check("mid_rst_in_ready", 64'(bus.in_ready), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      exp_enc = 0; exp_errc = 0;
      apply_vec(tab[0]);

      // random traffic against the model
      have_cur = 1'b0;
      prev_hold = 1'b0;
      prev_out = '0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         if (!have_cur && ($urandom_range(0, 9) < 7)) begin
            cur = rand_req();
            drive(cur);
            have_cur = 1'b1;
         end
         bus.in_valid  = have_cur;
         bus.out_ready = ($urandom_range(0, 3) != 0);
         #1;
         check("rnd_enc_cnt", 64'(encoded_count), 64'(exp_enc & 'hFFFF));
         check("rnd_err_cnt", 64'(error_count), 64'(exp_errc));
         got = {bus.out_error, bus.out_instruction};
         if (prev_hold) check("rnd_stable", 64'(got), 64'(prev_out));
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               check("rnd_unexpected_word", 64'(got), 64'd0);
               errors += (got == 33'd0) ? 1 : 0;
            end else begin
               check("rnd_word", 64'(got), 64'(exp_q.pop_front()));
               exp_enc++;
               if (bus.out_error) exp_errc++;
            end
         end
         prev_hold = bus.out_valid && !bus.out_ready;
         prev_out = got;
         if (bus.in_valid && bus.in_ready) begin
            exp_q.push_back(model(cur));
            have_cur = 1'b0;
         end
      end

      // drain whatever is left, bounded
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      for (int k = 0; k < 10 && exp_q.size() != 0; k++) begin
         #1;
         if (bus.out_valid) begin
            check("drain_word", 64'({bus.out_error, bus.out_instruction}), 64'(exp_q.pop_front()));
            exp_enc++;
            if (bus.out_error) exp_errc++;
         end
         @(negedge clk);
      end
      check("drain_left", 64'(exp_q.size()), 64'd0);
      check("final_enc_cnt", 64'(encoded_count), 64'(exp_enc & 'hFFFF));
      check("final_err_cnt", 64'(error_count), 64'(exp_errc));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/instruction_encoder.md
# instruction_encoder

Pipelined RISC-V instruction encoder. It takes an instruction type code, opcode/funct fields, register numbers and a full-width immediate, and packs them into a 32-bit instruction word. It is the inverse of the field-extraction decode stage and sits between the test-program generator / assembler front-end and the instruction memory loader. It adds a valid/ready handshake on both sides, a 2-entry output buffer, immediate range/alignment checking and statistics counters.

## Interface
- INSTRUCTION_LENGTH, 32, output word width
- TYPE_WIDTH, 3, type code width
- REGISTER_WIDTH, 5, register number width
- IMMEDIATE_WIDTH, 32, immediate input width
- COUNT_WIDTH, 16, counter width

- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  encoder can accept a request
- in_type  in  TYPE_WIDTH  R=0, I=1, S=2, SB=3, U=4, UJ=5; 6 and 7 are illegal
- in_opcode  in  7  opcode, goes to bits [6:0]
- in_funct3  in  3  goes to bits [14:12] (R/I/S/SB)
- in_funct7  in  7  goes to bits [31:25] (R, and I when shift)
- in_is_shift  in  1  I-type shift form
- in_rd, in_rs1, in_rs2  in  REGISTER_WIDTH  register numbers
- in_imm  in  IMMEDIATE_WIDTH  immediate, two's complement byte value
- out_valid  out  1  encoded word valid
- out_ready  in  1  consumer accepts
- out_instruction  out  INSTRUCTION_LENGTH  encoded word
- out_error  out  1  word was encoded from an illegal type or out-of-range immediate
- encoded_count  out  COUNT_WIDTH  output handshakes, wraps
- error_count  out  COUNT_WIDTH  output handshakes with out_error=1, saturates at all-ones

## Operation
- Encoding (bit ranges are of the output word):
  - R: funct7[31:25], rs2[24:20], rs1[19:15], funct3[14:12], rd[11:7], opcode[6:0].
  - I: imm[11:0]→[31:20], rs1, funct3, rd, opcode. Legal range is -2048..2047.
  - I, shift form: funct7→[31:25], imm[4:0]→[24:20]. Legal range is 0..31.
  - S: imm[11:5]→[31:25], imm[4:0]→[11:7], plus rs2, rs1, funct3. Legal range is -2048..2047.
  - SB: imm[12]→31, imm[10:5]→[30:25], imm[4:1]→[11:8], imm[11]→7. Legal range is -4096..4094, and imm[0] must be 0.
  - U: imm[31:12]→[31:12], rd, opcode. imm[11:0] must be 0.
  - UJ: imm[20]→31, imm[10:1]→[30:21], imm[11]→20, imm[19:12]→[19:12], rd, opcode. Legal range is -2^20..2^20-2, and imm[0] must be 0.
  - Illegal type: word = 0.
- Range is checked on the full signed IMMEDIATE_WIDTH value.
- A range or alignment violation sets out_error. The word is still produced from the truncated fields.
- Fields a type does not use are ignored.
- Buffering uses an output register plus one skid register.
  - in_ready = skid empty and reset deasserted.
  - An accepted request goes to the output register if that register is empty or draining this cycle. Otherwise it goes to the skid register.
  - On output drain, skid contents move to the output register.
  - Order is preserved.
- Counters update on the out_valid && out_ready edge.
  - encoded_count increments by 1 and wraps all-ones → 0.
  - error_count increments only when out_error=1 and holds at all-ones.

## Timing
- Reset values: out_valid=0, out_instruction=0, out_error=0, encoded_count=0, error_count=0, both buffer entries empty. in_ready=0 while reset is asserted and 1 in the first cycle after.
- Latency: a request accepted at edge N is presented with out_valid=1 after edge N, provided the output register was free. Throughput is 1 word/cycle with out_ready held high.
- out_instruction and out_error are stable while out_valid=1 and out_ready=0.
- Full condition (both entries occupied, out_ready=0): in_ready=0. in_ready returns to 1 the cycle after the first drain.
- Simultaneous accept and drain with the output register occupied and skid empty: the new word replaces the output register directly. Skid stays empty.
- Simultaneous accept and drain with both entries full: cannot occur, because in_ready=0.
- Reset mid-operation: buffered words are discarded and are not counted. All outputs return to their reset values asynchronously.

## Test plan
- R add: opcode 0x33, funct3 0, funct7 0, rd 3, rs1 1, rs2 2 → out_instruction 0x002081B3, out_error 0, encoded_count 1.
- I addi: opcode 0x13, rd 1, rs1 0, imm 0xFFFFFFFF → 0xFFF00093. Same request with imm 2048 → out_error 1, error_count 1.
- SB beq: opcode 0x63, rs1 1, rs2 2, imm -4 → 0xFE208EE3. Same request with imm 3 → out_error 1.
- UJ jal: opcode 0x6F, rd 1, imm 0x800 → 0x001000EF. Type 6 → word 0 with out_error 1.
- Backpressure: out_ready=0, offer 3 requests back-to-back. Two are accepted, then in_ready=0. Raise out_ready: the words emerge in order, the third is accepted one cycle after the first drain, and encoded_count ends at 3.
- Reset with both entries full: out_valid drops asynchronously and counters return to 0. After release, a new R request encodes with encoded_count 1.
